apb_bridge: RTL and testbench
=============================

Name: apb_bridge

Overview:
- Single-outstanding host-to-APB master bridge. It sits directly upstream of the APB register slaves (status/control register banks).
- Accepts a one-cycle host request and decodes the target slave from address bits. It then runs the APB SETUP/ACCESS sequence on one psel line, waits on that slave's pready, and returns read data and error status with a one-cycle ack.
- Slaves drive prdata to 0 when not selected, so the bridge takes a single pre-ORed prdata bus.

Parameters:
- NSLV, 4, number of APB slaves (1..16); one psel bit per slave.
- AW, 16, host and APB address width.
- SLV_LSB, 8, LSB of the slave-index field in the address. Index = addr[SLV_LSB +: 4].
- TIMEOUT, 16, maximum ACCESS cycles without pready before abort. 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  host request pulse; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; qualified by req.
- addr  in  AW  host byte address; qualified by req.
- wdata  in  32  host write data; qualified by req.
- busy  out  1  high whenever state is not IDLE.
- ack  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid with ack.
- rdata  out  32  read data; valid with ack.
- paddr  out  AW  APB address.
- pwrite  out  1  APB direction.
- psel  out  NSLV  one-hot slave select.
- penable  out  1  APB enable.
- pwdata  out  32  APB write data.
- prdata  in  32  OR of all slave prdata buses.
- pready  in  NSLV  per-slave ready.
- pslverr  in  NSLV  per-slave error.

Behaviour:
- Reset (async, reset_n low): state IDLE. busy, ack, err, psel, penable and pwrite are 0; paddr, pwdata and rdata are 0; timeout counter is 0.
- Reset mid-transaction drops psel/penable immediately; no ack is issued.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE with req=1:
  - Latch addr to paddr, wr to pwrite, and wdata to pwdata (pwdata latched only if wr=1, else 0).
  - Compute idx = addr[SLV_LSB+3:SLV_LSB].
  - If idx < NSLV: go to SETUP.
  - Else (decode error): go to RESP with err=1, rdata=0; no APB cycle and psel stays 0.
- SETUP (exactly 1 cycle): psel[idx]=1, penable=0, counter cleared. Next state is ACCESS.
- ACCESS: psel[idx]=1, penable=1. Only pready[idx]/pslverr[idx] are observed; other slaves' ready/err bits are ignored.
  - pready[idx]=1 at the edge:
    - Capture rdata = prdata if pwrite=0, else 0.
    - Capture err = pslverr[idx].
    - Drop psel/penable; go to RESP.
  - pready[idx]=0: counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT, abort: drop psel/penable, err=1, rdata=0, go to RESP.
- RESP (1 cycle): ack=1; err and rdata hold their captured values. Next state is IDLE.
  - ack is 0 in all other states.
  - err and rdata hold until the next ack.
- Latency, zero wait states:
  - req in cycle 0 → SETUP in cycle 1, ACCESS in cycle 2, ack in cycle 3.
  - Each wait state adds 1 cycle.
  - Next req is accepted in cycle 4 (minimum 4-cycle request spacing).
- req while busy=1, including the RESP cycle, is ignored: no queueing, no error.
- paddr, pwrite and pwdata stay stable from SETUP through ACCESS, then hold their values in IDLE. psel is never multi-hot.
- Slave read data: the slave registers prdata at the SETUP edge, so the value on prdata in ACCESS is the sampled value. The bridge never samples prdata outside an ACCESS-with-pready edge.

Test Plan:
- Zero-wait read, slave 1 (control16 reset 0x1234, status16=0xABCD tied): req, wr=0, addr=0x0108 → psel=4'b0010 in cycles 1-2, penable only in cycle 2, ack in cycle 3 with rdata=0xABCD1234, err=0.
- Write then read back, slave 1: write addr=0x0104, wdata=0xDEADBEEF → ack cycle 3, err=0, rdata=0. Read of 0x0104 → rdata=0xDEADBEEF.
- Wait states: slave 2 holds pready low 3 ACCESS cycles → penable high 4 cycles, ack in cycle 6. Assert pslverr[2] on the ready cycle → err=1.
- Decode error: addr=0x0500 with NSLV=4 → psel stays 0, ack in cycle 1, err=1, rdata=0.
- Timeout: TIMEOUT=16, slave 0 never ready → psel/penable drop after 16 ACCESS cycles, ack next cycle with err=1. Next request still completes normally.
- Robustness:
  - req pulses during busy are ignored; exactly one ack per accepted request.
  - reset_n low in ACCESS forces psel=0, penable=0, busy=0 immediately, with no ack after release.

Source files
------------

// File: rtl/apb_bridge_if.sv
// apb_bridge_if: groups the host request/response signals and the APB
// master-side bus of apb_bridge into one bundle.
//   master modport : the bridge (drives host response and APB request side)
//   slave modport  : everything around it (host and APB slaves)
// Host side : req, wr, addr, wdata -> bridge; busy, ack, err, rdata <- bridge
// APB side  : paddr, pwrite, psel, penable, pwdata <- bridge;
//             prdata (pre-ORed), pready, pslverr -> bridge
interface apb_bridge_if #(
    parameter int NSLV = 4,
    parameter int AW   = 16
);
    logic            req;
    logic            wr;
    logic [AW-1:0]   addr;
    logic [31:0]     wdata;
    logic            busy;
    logic            ack;
    logic            err;
    logic [31:0]     rdata;

    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [NSLV-1:0] psel;
    logic            penable;
    logic [31:0]     pwdata;
    logic [31:0]     prdata;
    logic [NSLV-1:0] pready;
    logic [NSLV-1:0] pslverr;

    modport master (
        input  req, wr, addr, wdata, prdata, pready, pslverr,
        output busy, ack, err, rdata, paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output req, wr, addr, wdata, prdata, pready, pslverr,
        input  busy, ack, err, rdata, paddr, pwrite, psel, penable, pwdata
    );
endinterface

// File: rtl/apb_bridge.sv
// apb_bridge: single-outstanding host-to-APB master bridge.
// A one-cycle host request is decoded to one of NSLV slaves using
// addr[SLV_LSB +: 4], run as an APB SETUP/ACCESS transfer, and completed
// with a one-cycle ack carrying err/rdata. Out-of-range slave indices
// complete immediately with err=1 and no APB cycle. ACCESS phases longer
// than TIMEOUT cycles are aborted with err=1 (TIMEOUT=0 waits forever).
// Ports:
//   pclk    : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : apb_bridge_if.master (host request/response + APB master bus)
module apb_bridge #(
    parameter int NSLV    = 4,
    parameter int AW      = 16,
    parameter int SLV_LSB = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          reset_n,
    apb_bridge_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int             CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);
    localparam logic [4:0]     NSLV_W = 5'(NSLV);

    state_t          state_reg, state_next;
    logic [3:0]      idx_reg, idx_next;
    logic [AW-1:0]   paddr_reg, paddr_next;
    logic            pwrite_reg, pwrite_next;
    logic [31:0]     pwdata_reg, pwdata_next;
    logic [31:0]     rdata_reg, rdata_next;
    logic            err_reg, err_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic [3:0]      req_idx;
    logic [NSLV-1:0] idx_onehot;
    logic            sel_active;
    logic            pready_sel;
    logic            pslverr_sel;
    logic [CW-1:0]   cnt_inc;
    logic            timeout_hit;

    assign req_idx = bus.addr[SLV_LSB +: 4];

    // Decoded slave index; reused both to drive psel and to pick out the
    // selected slave's pready/pslverr so other slaves' bits are masked off.
    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_dec
            assign idx_onehot[gi] = (idx_reg == 4'(gi));
        end
    endgenerate

    assign sel_active  = (state_reg == SETUP) || (state_reg == ACCESS);
    assign pready_sel  = |(bus.pready & idx_onehot);
    assign pslverr_sel = |(bus.pslverr & idx_onehot);
    assign cnt_inc     = cnt_reg + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

    // Bus controls decode straight from the state register so that an
    // asynchronous reset removes psel/penable without waiting for a clock.
    assign bus.psel    = sel_active ? idx_onehot : '0;
    assign bus.penable = (state_reg == ACCESS);
    assign bus.busy    = (state_reg != IDLE);
    assign bus.ack     = (state_reg == RESP);
    assign bus.err     = err_reg;
    assign bus.rdata   = rdata_reg;
    assign bus.paddr   = paddr_reg;
    assign bus.pwrite  = pwrite_reg;
    assign bus.pwdata  = pwdata_reg;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pwdata_reg <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            paddr_reg  <= paddr_next;
            pwrite_reg <= pwrite_next;
            pwdata_reg <= pwdata_next;
            rdata_reg  <= rdata_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        paddr_next  = paddr_reg;
        pwrite_next = pwrite_reg;
        pwdata_next = pwdata_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    paddr_next  = bus.addr;
                    pwrite_next = bus.wr;
                    pwdata_next = bus.wr ? bus.wdata : 32'h0;
                    idx_next    = req_idx;
                    if ({1'b0, req_idx} < NSLV_W) begin
                        state_next = SETUP;
                    end else begin
                        // Decode error: answer without touching the APB bus.
                        err_next   = 1'b1;
                        rdata_next = 32'h0;
                        state_next = RESP;
                    end
                end
            end
            SETUP: begin
                cnt_next   = '0;
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready_sel) begin
                    rdata_next = pwrite_reg ? 32'h0 : bus.prdata;
                    err_next   = pslverr_sel;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_inc;
                    if (timeout_hit) begin
                        err_next   = 1'b1;
                        rdata_next = 32'h0;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_apb_bridge.sv
module tb_apb_bridge;
    localparam int NSLV    = 4;
    localparam int AW      = 16;
    localparam int TIMEOUT = 16;
    localparam int NVEC    = 13;

    logic pclk;
    logic reset_n;

    apb_bridge_if #(.NSLV(NSLV), .AW(AW)) bus ();

    apb_bridge #(.NSLV(NSLV), .AW(AW), .SLV_LSB(8), .TIMEOUT(TIMEOUT)) dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks   = 0;
    int failures = 0;

    // ---------------- APB slave models ----------------
    logic [31:0] smem [NSLV][64];
    logic [31:0] srd  [NSLV];
    int          wcnt [NSLV];
    int          wait_cfg [NSLV];
    bit          err_cfg  [NSLV];
    logic [3:0]  noise_rdy, noise_err;
    bit          mem_init;

    always @(posedge pclk) begin
        if (mem_init) begin
            for (int s = 0; s < NSLV; s++)
                for (int w = 0; w < 64; w++)
                    smem[s][w] <= 32'hC0DE0000 | (s << 8) | w;
            smem[1][2] <= 32'hABCD1234;
        end else begin
            for (int s = 0; s < NSLV; s++)
                if (bus.psel[s] && bus.penable && bus.pready[s] && bus.pwrite)
                    smem[s][bus.paddr[7:2]] <= bus.pwdata;
        end
        for (int s = 0; s < NSLV; s++) begin
            if (bus.psel[s] && !bus.penable) srd[s] <= smem[s][bus.paddr[7:2]];
            wcnt[s] <= (bus.psel[s] && bus.penable) ? wcnt[s] + 1 : 0;
        end
        noise_rdy <= 4'($urandom);
        noise_err <= 4'($urandom);
    end

    always_comb begin
        bus.prdata  = 32'h0;
        bus.pready  = '0;
        bus.pslverr = '0;
        for (int s = 0; s < NSLV; s++) begin
            if (bus.psel[s]) bus.prdata = bus.prdata | srd[s];
            if (bus.psel[s] && bus.penable) begin
                bus.pready[s]  = (wcnt[s] >= wait_cfg[s]);
                bus.pslverr[s] = err_cfg[s];
            end else begin
                bus.pready[s]  = noise_rdy[s];
                bus.pslverr[s] = noise_err[s];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] mref [NSLV][64];

    // Expected outcome straight from the transaction rules: decode error,
    // timeout, or completion after the slave's wait states.
    function automatic void model(input logic w, input logic [15:0] a, input logic [31:0] d,
                                  output int lat, output logic e, output logic [31:0] r);
        int idx = int'(a[11:8]);
        int wd  = int'(a[7:2]);
        if (idx >= NSLV) begin
            lat = 1; e = 1'b1; r = 32'h0;
        end else if (wait_cfg[idx] >= TIMEOUT) begin
            lat = 2 + TIMEOUT; e = 1'b1; r = 32'h0;
        end else begin
            lat = 3 + wait_cfg[idx];
            e   = err_cfg[idx];
            r   = w ? 32'h0 : mref[idx][wd];
            if (w) mref[idx][wd] = d;
        end
    endfunction

    typedef struct {
        int          lat;
        logic        e;
        logic [31:0] r;
        int          psel_cyc;
        int          pen_cyc;
        bit          psel_bad;
        logic [15:0] pa;
        bit          tail_bad;
    } res_t;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        int          wt;
        bit          se;
        logic        e;
        logic [31:0] r;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One request pulse, then watch the bus until ack (bounded). With noise
    // set, req/addr/wr/wdata are scrambled while the bridge is busy.
    task automatic do_txn(input logic w, input logic [15:0] a, input logic [31:0] d,
                          input bit noise, output res_t res);
        logic [3:0] exp_sel;
        res = '{-1, 1'bx, 32'hx, 0, 0, 1'b0, 16'hx, 1'b0};
        exp_sel = (a[11:8] < 4'(NSLV)) ? (4'b0001 << a[11:8]) : 4'b0000;
        @(negedge pclk);
        bus.req = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
        for (int c = 1; c <= 100; c++) begin
            @(negedge pclk);
            bus.req = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                bus.wr = 1'($urandom); bus.addr = 16'($urandom); bus.wdata = $urandom;
            end
            if (bus.psel != 0) res.psel_cyc++;
            if (bus.penable) res.pen_cyc++;
            if (bus.psel != 0 && bus.psel != exp_sel) res.psel_bad = 1'b1;
            if (bus.ack) begin
                res.lat = c; res.e = bus.err; res.r = bus.rdata; res.pa = bus.paddr;
                break;
            end
        end
        @(negedge pclk);
        bus.req = 1'b0;
        res.tail_bad = bus.ack || bus.busy;
    endtask

    task automatic verify(input string tag, input logic w, input logic [15:0] a, input res_t res,
                          input int lat, input logic e, input logic [31:0] r);
        $display("%s wr=%0b addr=%h lat=%0d err=%0b rdata=%h psel_cyc=%0d pen_cyc=%0d",
                 tag, w, a, res.lat, res.e, res.r, res.psel_cyc, res.pen_cyc);
        chk({tag, " latency"}, 64'(res.lat), 64'(lat));
        chk({tag, " err"}, 64'(res.e), 64'(e));
        chk({tag, " rdata"}, 64'(res.r), 64'(r));
        chk({tag, " psel_cycles"}, 64'(res.psel_cyc), 64'(lat - 1));
        chk({tag, " penable_cycles"}, 64'(res.pen_cyc), 64'((lat > 1) ? lat - 2 : 0));
        chk({tag, " psel_onehot"}, 64'(res.psel_bad), 64'(0));
        chk({tag, " paddr"}, 64'(res.pa), 64'(a));
        chk({tag, " ack_single"}, 64'(res.tail_bad), 64'(0));
    endtask

    initial begin
        vec_t        vecs [NVEC];
        res_t        res;
        int          mlat, idx, acks;
        logic        me;
        logic [31:0] mr, cap;
        logic        w;
        logic [15:0] a;
        logic [31:0] d;

        vecs[0]  = '{1'b0, 16'h0108, 32'h0,        0,    1'b0, 1'b0, 32'hABCD1234, 3};
        vecs[1]  = '{1'b1, 16'h0104, 32'hDEADBEEF, 0,    1'b0, 1'b0, 32'h0,        3};
        vecs[2]  = '{1'b0, 16'h0104, 32'h0,        0,    1'b0, 1'b0, 32'hDEADBEEF, 3};
        vecs[3]  = '{1'b0, 16'h0200, 32'h0,        3,    1'b1, 1'b1, 32'hC0DE0200, 6};
        vecs[4]  = '{1'b0, 16'h0500, 32'h0,        0,    1'b0, 1'b1, 32'h0,        1};
        vecs[5]  = '{1'b0, 16'h0000, 32'h0,        1000, 1'b0, 1'b1, 32'h0,        18};
        vecs[6]  = '{1'b0, 16'h0004, 32'h0,        0,    1'b0, 1'b0, 32'hC0DE0001, 3};
        vecs[7]  = '{1'b0, 16'h030C, 32'h0,        15,   1'b0, 1'b0, 32'hC0DE0303, 18};
        vecs[8]  = '{1'b1, 16'h0F00, 32'h12345678, 0,    1'b0, 1'b1, 32'h0,        1};
        vecs[9]  = '{1'b1, 16'h0310, 32'hCAFEF00D, 1,    1'b1, 1'b1, 32'h0,        4};
        vecs[10] = '{1'b0, 16'h0310, 32'h0,        0,    1'b0, 1'b0, 32'hCAFEF00D, 3};
        vecs[11] = '{1'b1, 16'h0008, 32'h55AA55AA, 16,   1'b0, 1'b1, 32'h0,        18};
        vecs[12] = '{1'b0, 16'h0008, 32'h0,        0,    1'b0, 1'b0, 32'hC0DE0002, 3};

        for (int s = 0; s < NSLV; s++) begin
            wait_cfg[s] = 0;
            err_cfg[s]  = 1'b0;
            for (int wd = 0; wd < 64; wd++) mref[s][wd] = 32'hC0DE0000 | (s << 8) | wd;
        end
        mref[1][2] = 32'hABCD1234;

        bus.req = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        mem_init = 1'b1;
        reset_n  = 1'b0;
        repeat (2) @(negedge pclk);
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset ack", 64'(bus.ack), 64'(0));
        chk("reset err", 64'(bus.err), 64'(0));
        chk("reset psel", 64'(bus.psel), 64'(0));
        chk("reset penable", 64'(bus.penable), 64'(0));
        chk("reset pwrite", 64'(bus.pwrite), 64'(0));
        chk("reset paddr", 64'(bus.paddr), 64'(0));
        chk("reset pwdata", 64'(bus.pwdata), 64'(0));
        chk("reset rdata", 64'(bus.rdata), 64'(0));
        mem_init = 1'b0;
        reset_n  = 1'b1;

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            idx = int'(vecs[i].a[11:8]);
            if (idx < NSLV) begin
                wait_cfg[idx] = vecs[i].wt;
                err_cfg[idx]  = vecs[i].se;
            end
            model(vecs[i].w, vecs[i].a, vecs[i].d, mlat, me, mr);
            do_txn(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, res);
            verify($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, res,
                   vecs[i].lat, vecs[i].e, vecs[i].r);
        end

        // req held for two cycles: the second cycle lands in SETUP and is ignored.
        wait_cfg[1] = 0; err_cfg[1] = 1'b0;
        acks = 0; cap = 32'h0;
        @(negedge pclk);
        bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0108;
        @(negedge pclk);
        bus.addr = 16'h0204;
        @(negedge pclk);
        bus.req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.ack) begin acks++; cap = bus.rdata; end
            @(negedge pclk);
        end
        $display("double_req acks=%0d rdata=%h busy=%0b", acks, cap, bus.busy);
        chk("double_req acks", 64'(acks), 64'(1));
        chk("double_req rdata", 64'(cap), 64'(32'hABCD1234));
        chk("double_req busy", 64'(bus.busy), 64'(0));

        // Randomised traffic with busy-time req noise, against the model.
        for (int t = 0; t < 40; t++) begin
            int r;
            idx = $urandom_range(0, 5);
            r   = $urandom_range(0, 9);
            w   = 1'($urandom);
            d   = $urandom;
            a   = {4'($urandom_range(0, 15)), 4'(idx), 6'($urandom_range(0, 63)),
                   2'($urandom_range(0, 3))};
            if (idx < NSLV) begin
                wait_cfg[idx] = (r < 7) ? r % 5 : ((r == 7) ? 15 : 16 + $urandom_range(0, 3));
                err_cfg[idx]  = 1'($urandom);
            end
            model(w, a, d, mlat, me, mr);
            do_txn(w, a, d, 1'b1, res);
            verify($sformatf("rnd%0d", t), w, a, res, mlat, me, mr);
        end

        // Reset in the middle of ACCESS.
        wait_cfg[0] = 1000;
        @(negedge pclk);
        bus.req = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0000;
        @(negedge pclk);
        bus.req = 1'b0;
        @(negedge pclk);
        chk("midreset in_access", 64'(bus.penable), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        $display("midreset psel=%b penable=%0b busy=%0b", bus.psel, bus.penable, bus.busy);
        chk("midreset psel", 64'(bus.psel), 64'(0));
        chk("midreset penable", 64'(bus.penable), 64'(0));
        chk("midreset busy", 64'(bus.busy), 64'(0));
        @(negedge pclk);
        reset_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge pclk);
            if (bus.ack) acks++;
        end
        chk("midreset no_ack", 64'(acks), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
